// File: rtl/riscv_defines.sv
// Shared types for the branch prediction metadata that rides alongside
// instructions from fetch to execute.
package riscv_defines;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic [31:0] target;
    } pred_meta_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pred_meta_stage.sv
// One prediction-metadata pipeline register. A flush clears only the valid
// bit, and a flush takes priority over a stall.
module pred_meta_stage
    import riscv_defines::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  pred_meta_t meta_in,
    output pred_meta_t meta_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
        end else if (flush) begin
            meta_q.valid <= 1'b0;
        end else if (!stall) begin
            meta_q <= meta_in;
        end
    end

endmodule

// File: rtl/branch_resolution_unit.sv
// Carries fetch predictions through D/E, resolves them in execute, and drives
// the BHT update, the fetch redirect and the saturating performance counters.
module branch_resolution_unit
    import riscv_defines::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_f,
    input  logic                 pred_taken_f,
    input  logic [31:0]          pred_target_f,
    input  logic                 stall_d,
    input  logic                 stall_e,
    input  logic                 flush_d,
    input  logic                 flush_e,
    input  logic [31:0]          pc_e,
    input  logic                 is_branch_e,
    input  logic                 is_jump_e,
    input  logic                 cflow_taken_e,
    input  logic [31:0]          cflow_target_e,
    output logic                 bht_update,
    output logic                 bht_outcome,
    output logic                 mispredict_e,
    output logic [31:0]          redirect_pc_e,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    pred_meta_t meta_f_p0;
    pred_meta_t meta_p0;
    pred_meta_t meta_d_p1;
    pred_meta_t meta_p1;

    logic vld_p1;
    logic cflow;
    logic actual;
    logic raw_mispredict;
    logic resolve_ok;

    assign meta_f_p0 = '{valid: valid_f, taken: pred_taken_f, target: pred_target_f};

    // ---- D stage: fetch -> decode ----
    pred_meta_stage u_meta_d (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall_d),
        .flush   (flush_d | mispredict_e),
        .meta_in (meta_f_p0),
        .meta_q  (meta_p0)
    );

    // A held D with a moving E must not duplicate D's instruction into E.
    always_comb begin
        meta_d_p1 = meta_p0;
        if (stall_d) begin
            meta_d_p1.valid = 1'b0;
        end
    end

    // ---- E stage: decode -> execute ----
    pred_meta_stage u_meta_e (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall_e),
        .flush   (flush_e | mispredict_e),
        .meta_in (meta_d_p1),
        .meta_q  (meta_p1)
    );

    assign vld_p1 = meta_p1.valid;
    assign cflow  = is_branch_e | is_jump_e;
    assign actual = is_jump_e | (is_branch_e & cflow_taken_e);

    // A taken prediction on a non-control-flow instruction is an aliased BTB hit.
    assign raw_mispredict = (cflow & (meta_p1.taken != actual))
                          | (cflow & actual & meta_p1.taken & (meta_p1.target != cflow_target_e))
                          | (~cflow & meta_p1.taken);

    assign resolve_ok    = vld_p1 & ~stall_e;
    assign mispredict_e  = raw_mispredict & resolve_ok;
    assign redirect_pc_e = mispredict_e ? (actual ? cflow_target_e : pc_e + PC_STEP) : 32'd0;
    assign bht_update    = resolve_ok & is_branch_e;
    assign bht_outcome   = cflow_taken_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (resolve_ok & cflow) begin
                branch_cnt <= sat_inc(branch_cnt);
            end
            if (mispredict_e) begin
                mispredict_cnt <= sat_inc(mispredict_cnt);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Scoreboard bench for branch_resolution_unit: stimulus queues expected
// execute-stage responses, a negedge monitor pops and compares them.
module tb_branch_resolution_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        stall_d, stall_e, flush_d, flush_e;
    logic [31:0] pc_e;
    logic        is_branch_e, is_jump_e, cflow_taken_e;
    logic [31:0] cflow_target_e;
    logic        bht_update, bht_outcome, mispredict_e;
    logic [31:0] redirect_pc_e;
    logic [31:0] branch_cnt, mispredict_cnt;

    typedef struct packed {
        logic        mis;
        logic [31:0] redir;
        logic        upd;
        logic        outc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    branch_resolution_unit #(.CNT_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_f        (valid_f),
        .pred_taken_f   (pred_taken_f),
        .pred_target_f  (pred_target_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .pc_e           (pc_e),
        .is_branch_e    (is_branch_e),
        .is_jump_e      (is_jump_e),
        .cflow_taken_e  (cflow_taken_e),
        .cflow_target_e (cflow_target_e),
        .bht_update     (bht_update),
        .bht_outcome    (bht_outcome),
        .mispredict_e   (mispredict_e),
        .redirect_pc_e  (redirect_pc_e),
        .branch_cnt     (branch_cnt),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: any visible execute-stage response must match the queue head.
    always @(negedge clk) begin
        if (rst_n && (mispredict_e || bht_update)) begin
            exp_t act, e;
            act = '{mis: mispredict_e, redir: redirect_pc_e, upd: bht_update, outc: bht_outcome};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual mis=%0b redir=0x%0h upd=%0b out=%0b required none",
                         act.mis, act.redir, act.upd, act.outc);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL resolve_output actual mis=%0b redir=0x%0h upd=%0b out=%0b required mis=%0b redir=0x%0h upd=%0b out=%0b",
                             act.mis, act.redir, act.upd, act.outc, e.mis, e.redir, e.upd, e.outc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_e();
        is_branch_e    = 1'b0;
        is_jump_e      = 1'b0;
        cflow_taken_e  = 1'b0;
        pc_e           = 32'd0;
        cflow_target_e = 32'd0;
    endtask

    task automatic set_fetch(input logic pt, input logic [31:0] tgt);
        valid_f       = 1'b1;
        pred_taken_f  = pt;
        pred_target_f = tgt;
    endtask

    task automatic no_fetch();
        valid_f       = 1'b0;
        pred_taken_f  = 1'b0;
        pred_target_f = 32'd0;
    endtask

    // Fetch one prediction and advance it into E (two edges).
    task automatic fetch_to_e(input logic pt, input logic [31:0] tgt);
        set_fetch(pt, tgt);
        step();
        no_fetch();
        step();
    endtask

    task automatic resolve(input logic br, input logic jmp, input logic tk,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic mis, input logic [31:0] redir);
        is_branch_e    = br;
        is_jump_e      = jmp;
        cflow_taken_e  = tk;
        pc_e           = pc;
        cflow_target_e = tgt;
        if (mis || br) sb.push_back('{mis: mis, redir: redir, upd: br, outc: tk});
        step();
        clear_e();
    endtask

    initial begin
        rst_n = 1'b0;
        stall_d = 1'b0; stall_e = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
        no_fetch();
        clear_e();
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("reset_mispredict", {31'd0, mispredict_e}, 32'd0);
        chk("reset_bht_update", {31'd0, bht_update}, 32'd0);
        chk("reset_redirect", redirect_pc_e, 32'd0);
        chk("reset_branch_cnt", branch_cnt, 32'd0);
        chk("reset_mispredict_cnt", mispredict_cnt, 32'd0);

        // Correct not-taken branch.
        fetch_to_e(1'b0, 32'd0);
        resolve(1'b1, 1'b0, 1'b0, 32'h10, 32'h14, 1'b0, 32'd0);
        chk("nt_branch_cnt", branch_cnt, 32'd1);
        chk("nt_mispredict_cnt", mispredict_cnt, 32'd0);

        // Direction miss at 0x100 -> 0x80, with a younger taken prediction held in D.
        set_fetch(1'b0, 32'd0);
        step();
        set_fetch(1'b1, 32'h777);
        step();
        no_fetch();
        stall_d = 1'b1;
        resolve(1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80);
        stall_d = 1'b0;
        chk("squash_d_valid", {31'd0, dut.meta_p0.valid}, 32'd0);
        chk("squash_e_valid", {31'd0, dut.meta_p1.valid}, 32'd0);
        chk("dir_branch_cnt", branch_cnt, 32'd2);
        chk("dir_mispredict_cnt", mispredict_cnt, 32'd1);
        step();
        step();

        // JALR target miss: predicted 0x200, actual 0x300.
        fetch_to_e(1'b1, 32'h200);
        resolve(1'b0, 1'b1, 1'b0, 32'h50, 32'h300, 1'b1, 32'h300);
        chk("jalr_branch_cnt", branch_cnt, 32'd3);
        chk("jalr_mispredict_cnt", mispredict_cnt, 32'd2);

        // Aliased taken prediction on a non-branch at 0x40.
        fetch_to_e(1'b1, 32'h123);
        resolve(1'b0, 1'b0, 1'b0, 32'h40, 32'd0, 1'b1, 32'h44);
        chk("alias_branch_cnt", branch_cnt, 32'd3);
        chk("alias_mispredict_cnt", mispredict_cnt, 32'd3);

        // Correct taken jump: counted, silent.
        fetch_to_e(1'b1, 32'h300);
        resolve(1'b0, 1'b1, 1'b0, 32'h60, 32'h300, 1'b0, 32'd0);
        chk("hit_branch_cnt", branch_cnt, 32'd4);
        chk("hit_mispredict_cnt", mispredict_cnt, 32'd3);

        // Mispredicting branch held in E for three cycles.
        fetch_to_e(1'b0, 32'd0);
        stall_e        = 1'b1;
        is_branch_e    = 1'b1;
        cflow_taken_e  = 1'b1;
        pc_e           = 32'h200;
        cflow_target_e = 32'h240;
        for (int i = 0; i < 3; i++) begin
            chk("stall_mispredict", {31'd0, mispredict_e}, 32'd0);
            step();
        end
        chk("stall_branch_cnt", branch_cnt, 32'd4);
        chk("stall_mispredict_cnt", mispredict_cnt, 32'd3);
        stall_e = 1'b0;
        sb.push_back('{mis: 1'b1, redir: 32'h240, upd: 1'b1, outc: 1'b1});
        step();
        chk("release_single_pulse", {31'd0, mispredict_e}, 32'd0);
        clear_e();
        chk("release_branch_cnt", branch_cnt, 32'd5);
        chk("release_mispredict_cnt", mispredict_cnt, 32'd4);

        // flush_d with stall_d: E takes a bubble, D is emptied.
        set_fetch(1'b1, 32'h999);
        step();
        no_fetch();
        stall_d = 1'b1;
        flush_d = 1'b1;
        step();
        stall_d = 1'b0;
        flush_d = 1'b0;
        chk("bubble_e_valid", {31'd0, dut.meta_p1.valid}, 32'd0);
        chk("flush_d_valid", {31'd0, dut.meta_p0.valid}, 32'd0);
        step();
        step();
        chk("bubble_branch_cnt", branch_cnt, 32'd5);

        // Saturation from all-ones.
        fetch_to_e(1'b0, 32'd0);
        force dut.branch_cnt = 32'hFFFF_FFFF;
        force dut.mispredict_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt;
        release dut.mispredict_cnt;
        resolve(1'b1, 1'b0, 1'b1, 32'h300, 32'h380, 1'b1, 32'h380);
        fetch_to_e(1'b0, 32'd0);
        resolve(1'b1, 1'b0, 1'b0, 32'h400, 32'h480, 1'b0, 32'd0);
        chk("sat_branch_cnt", branch_cnt, 32'hFFFF_FFFF);
        chk("sat_mispredict_cnt", mispredict_cnt, 32'hFFFF_FFFF);

        // Reset mid-cycle with a mispredicting branch in E.
        fetch_to_e(1'b1, 32'h500);
        is_branch_e    = 1'b1;
        cflow_taken_e  = 1'b1;
        pc_e           = 32'h60;
        cflow_target_e = 32'h600;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mispredict", {31'd0, mispredict_e}, 32'd0);
        chk("rst_mid_bht_update", {31'd0, bht_update}, 32'd0);
        chk("rst_mid_redirect", redirect_pc_e, 32'd0);
        chk("rst_mid_branch_cnt", branch_cnt, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_no_count", branch_cnt, 32'd0);
        clear_e();
        fetch_to_e(1'b0, 32'd0);
        resolve(1'b1, 1'b0, 1'b0, 32'h70, 32'h74, 1'b0, 32'd0);
        chk("post_rst_branch_cnt", branch_cnt, 32'd1);
        chk("post_rst_mispredict_cnt", mispredict_cnt, 32'd0);

        step();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
# branch_resolution_unit

Carries fetch-stage branch predictions (BHT direction plus BTB target) through the decode and execute pipeline registers. Resolves each prediction in execute against the actual control-flow outcome. Drives the BHT update port, the misprediction redirect to the fetch PC mux, and saturating branch and misprediction counters. Sits between the fetch-side predictors and the execute stage.

## Interface
- `CNT_WIDTH`, 32: width of both performance counters.
- `clk`  in  1: core clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `valid_f`  in  1: fetch stage holds a real instruction.
- `pred_taken_f`  in  1: BHT direction prediction for `pc_f`.
- `pred_target_f`  in  32: BTB target predicted for `pc_f`.
- `stall_d`, `stall_e`  in  1 each: hazard-unit holds of the D and E pipeline registers.
- `flush_d`, `flush_e`  in  1 each: hazard-unit squashes of the D and E pipeline registers.
- `pc_e`  in  32: PC of the instruction in execute.
- `is_branch_e`  in  1: execute holds a conditional branch.
- `is_jump_e`  in  1: execute holds JAL or JALR.
- `cflow_taken_e`  in  1: actual branch outcome; ignored when `is_jump_e` is set.
- `cflow_target_e`  in  32: actual computed target.
- `bht_update`  out  1: BHT update strobe (the BHT `is_branch` input).
- `bht_outcome`  out  1: outcome written to the BHT (the BHT `cflow_taken` input).
- `mispredict_e`  out  1: redirect fetch and squash the younger stages.
- `redirect_pc_e`  out  32: correct next PC.
- `branch_cnt`  out  CNT_WIDTH: count of resolved control-flow instructions.
- `mispredict_cnt`  out  CNT_WIDTH: count of mispredictions.

## Operation
- **Metadata pipeline.** Two metadata registers, D and E, each holding {valid, taken, target}.
  - Each register loads from the previous stage when not stalled.
  - The D register loads `valid_f`, `pred_taken_f` and `pred_target_f`.
- **Register update priority, per register:**
  1. Flush (the stage's own flush, or a qualified mispredict) clears `valid` only.
  2. Otherwise, stall holds the register.
  3. Otherwise, the register loads.
- **Bubble from D to E.** If `stall_d` is high and `stall_e` is low, E loads a bubble (`valid`=0).
- **Resolution.** It is combinational in execute and applies only when `E.valid` is set.
  - `cflow = is_branch_e | is_jump_e`.
  - `actual = is_jump_e | (is_branch_e & cflow_taken_e)`.
- **Raw mispredict** is any of the following:
  - `cflow` and `E.taken != actual`.
  - `cflow`, `actual`, `E.taken`, and `E.target != cflow_target_e`.
  - Not `cflow` while `E.taken` is 1 (aliased prediction).
- **Qualified outputs.** `mispredict_e = raw & E.valid & ~stall_e`.
- **Redirect PC.**
  - When `mispredict_e` is 1: `cflow_target_e` if `actual` is 1, otherwise `pc_e + 4` (32-bit, wraps modulo 2^32).
  - When `mispredict_e` is 0: 0.
- **Squash.** A qualified mispredict clears `D.valid` and `E.valid` at the next edge, whatever `flush_*` and `stall_d` are.
- **BHT port.**
  - `bht_update = E.valid & is_branch_e & ~stall_e`. Jumps never train the BHT.
  - `bht_outcome = cflow_taken_e`.
- **Counters.** At the edge, if `E.valid & cflow & ~stall_e`:
  - `branch_cnt` increments.
  - `mispredict_cnt` also increments if raw mispredict is set.
  - Aliased mispredicts (not `cflow`) increment only `mispredict_cnt`.
  - Both counters saturate at all-ones.

## Timing
- **Reset (async assert, sync release).**
  - All metadata valid bits are 0; target fields are 0.
  - Both counters are 0.
  - Hence `mispredict_e`, `bht_update` and `redirect_pc_e` are all 0.
- **Pipeline latency.** A prediction captured at fetch edge N appears in E after edge N+1, assuming no stalls.
- **Combinational outputs.** `mispredict_e`, `redirect_pc_e`, `bht_update` and `bht_outcome` are combinational in the same cycle the instruction is in E. There is zero added latency, so the BHT writes at the edge ending that cycle.
- **Stalled E.** While `stall_e` holds a branch in E, all outputs stay 0. They assert exactly once, in the cycle E releases, so there is no double count and no double BHT update.
- **Simultaneous events.**
  - `flush_e` together with a mispredict: E clears, and the resolving instruction still counts that cycle.
  - A mispredict together with `stall_d`: the squash wins.
- **Reset mid-operation.** Reset clears in-flight predictions immediately. No redirect is generated.

## Structure
- Shared package `riscv_defines`:
  - `pred_meta_t` packed struct {`valid`, `taken`, `target[31:0]`}.
  - `PC_STEP` = 4.
- Sub-module `pred_meta_stage`: one `pred_meta_t` register with async active-low reset and flush-over-stall priority, instantiated for D and E.
- The top level holds resolution, qualification and the counters.

## Test plan
- **Correct not-taken.** Predict not-taken at fetch; execute a branch with `cflow_taken_e`=0 and no stalls → `mispredict_e`=0, `bht_update`=1, `bht_outcome`=0, `branch_cnt`=1, `mispredict_cnt`=0.
- **Direction miss.** Predict not-taken; execute a branch at `pc_e`=0x100, taken to 0x80 → `mispredict_e`=1, `redirect_pc_e`=0x80. D and E valid are 0 on the next cycle; `mispredict_cnt`=1.
- **Target miss and aliasing.**
  - Predict taken with target 0x200; JALR resolves to 0x300 → mispredict, redirect 0x300, `bht_update`=0.
  - Non-branch at 0x40 with `E.taken`=1 → redirect 0x44; `branch_cnt` is unchanged.
- **Stalled branch.** Hold a mispredicting branch with `stall_e`=1 for 3 cycles → outputs 0 throughout. On release, a single 1-cycle `mispredict_e` and exactly one increment of each counter.
- **Flush and saturation.**
  - Assert `flush_d` while `stall_d`=1 → E receives a bubble.
  - Preload counters to all-ones via force, then resolve 2 branches → counters stay all-ones.
- **Reset mid-operation.** Assert `rst_n`=0 mid-cycle with a valid branch in E → all outputs 0 asynchronously; after release, the first resolution requires a fresh fetch.
